range_sample_loader: RTL and testbench
======================================

Name: range_sample_loader

Overview:
- Upstream feeder for the 10-bit RangeFinder stage.
- Accepts a sample sequence from chip pins or a host in bursts that may have gaps, and buffers it in an internal store.
- Replays the sequence to the RangeFinder gap-free, one sample per cycle, framed by go/finish.
- Flags overflow and protocol errors so the chip top level can expose them.

Parameters:
- WIDTH, 10, sample width in bits; must match the RangeFinder data width.
- DEPTH, 16, maximum samples per sequence; must be ≥ 2.

Ports:
- clock  input  1  system clock; all state is updated on the rising edge.
- reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
- in_data  input  WIDTH  incoming sample.
- in_valid  input  1  in_data is valid this cycle.
- in_last  input  1  qualified by in_valid; this sample ends the sequence.
- in_ready  output  1  loader accepts a sample this cycle. A sample is accepted when in_valid && in_ready.
- data_out  output  WIDTH  sample to the RangeFinder data_in.
- go  output  1  one-cycle pulse, coincident with the first replayed sample.
- finish  output  1  one-cycle pulse, the cycle after the last replayed sample.
- busy  output  1  high in PLAY.
- overflow  output  1  sticky: a sequence exceeded DEPTH.

Behaviour:
- Reset values (reset=0): state=IDLE, count=0, rd_ptr=0, in_ready=1, data_out=0, go=0, finish=0, busy=0, overflow=0.
- All outputs are registered. in_ready is decoded from registered state only.
- Storage: DEPTH x WIDTH register array. Count and pointers are $clog2(DEPTH+1) bits wide.

State machine:
- IDLE
  - in_ready=1.
  - An accepted sample is written to buf[0] and count becomes 1.
  - If in_last is also set, go to PLAY; otherwise go to FILL.
- FILL
  - in_ready=1.
  - Each accepted sample is written to buf[count] and count increments.
  - An accepted sample with in_last goes to PLAY.
  - An accepted sample while count==DEPTH, without or with in_last: the sample is dropped, overflow=1, count=0, go to IDLE. The partial sequence is discarded and no go is issued.
  - An accepted in_last sample arriving when count==DEPTH-1 is legal and fills the buffer exactly.
- PLAY
  - in_ready=0 and busy=1. in_valid is ignored and nothing is stored.
  - First PLAY cycle: go=1, data_out=buf[0].
  - Each following cycle: data_out=buf[i], i=1..count-1, with go=0.
  - The cycle after the last sample: finish=1, and data_out holds the last sample.
  - Next cycle: back to IDLE with count=0.
  - overflow clears on entry to PLAY.
- Single-sample sequence: go with buf[0], then finish on the next cycle, so replay is 2 cycles.

Latency:
- The sample carrying in_last is accepted at edge T. go and the first data_out are high in the cycle after edge T+1.
- Replay occupies count+1 cycles.
- go and finish are never high in the same cycle.

Other rules:
- No back-to-back overlap: a new sequence can be accepted at the earliest in the cycle after finish.
- data_out is not changed in IDLE/FILL; it holds its last value.
- Reset asserted mid-FILL or mid-PLAY: everything returns to reset values asynchronously. Any go/finish in progress is cut off, and no finish is issued after reset releases.
- Reset release is synchronous to clock; the design deasserts reset externally.

Test Plan:
- Samples 5, 9, 2, 7 (last on 7) with gaps between them → go=1 with data_out=5, then 9, 2, 7 on consecutive cycles, then finish=1 with data_out=7; busy is high for 5 cycles.
- Single sample 0x3FF with in_last → go with data_out=0x3FF, next cycle finish=1, then in_ready=1.
- 16 samples 1..16, last on 16 → full replay, no overflow. Then 17 samples with no last → overflow=1 on the 17th, state IDLE, no go. A following valid 2-sample sequence clears overflow at go.
- in_valid held high with data 0x155 throughout PLAY → in_ready=0; the replayed values are unchanged and the post-finish buffer contains only new data.
- reset driven 0 in the cycle after go of a 4-sample sequence → go/finish/busy/in_ready = 0/0/0/1 immediately; no finish after release.

Source files
------------

// File: rtl/range_sample_loader.sv
// Buffers a burst-fed sample sequence and replays it gap-free to the RangeFinder,
// framed by one-cycle go/finish pulses, with a sticky overflow flag.
module range_sample_loader #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [WIDTH-1:0] data_out,
    output logic             go,
    output logic             finish,
    output logic             busy,
    output logic             overflow
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    // S_DONE is the cycle finish is visible; in_ready stays low through it.
    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_PLAY,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [CW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             go_q, go_d;
    logic             finish_q, finish_d;
    logic             busy_q, busy_d;
    logic             overflow_q, overflow_d;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic             accept;

    assign in_ready = (state_q == S_IDLE) || (state_q == S_FILL);
    assign accept   = in_valid && in_ready;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        state_d    = state_q;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        data_out_d = data_out_q;
        go_d       = 1'b0;
        finish_d   = 1'b0;
        busy_d     = 1'b0;
        overflow_d = overflow_q;
        wr_en      = 1'b0;
        wr_addr    = count_q[AW-1:0];

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    wr_en   = 1'b1;
                    wr_addr = '0;
                    count_d = CW'(1);
                    if (in_last) begin
                        state_d    = S_PLAY;
                        rd_ptr_d   = '0;
                        overflow_d = 1'b0;
                    end else begin
                        state_d = S_FILL;
                    end
                end
            end
            S_FILL: begin
                if (accept) begin
                    if (count_q == DEPTH_C) begin
                        // Buffer already full: drop the sample and the partial sequence.
                        overflow_d = 1'b1;
                        count_d    = '0;
                        state_d    = S_IDLE;
                    end else begin
                        wr_en   = 1'b1;
                        count_d = count_q + 1'b1;
                        if (in_last) begin
                            state_d    = S_PLAY;
                            rd_ptr_d   = '0;
                            overflow_d = 1'b0;
                        end
                    end
                end
            end
            S_PLAY: begin
                busy_d = 1'b1;
                if (rd_ptr_q < count_q) begin
                    data_out_d = mem_q[rd_ptr_q[AW-1:0]];
                    go_d       = (rd_ptr_q == '0);
                    rd_ptr_d   = rd_ptr_q + 1'b1;
                end else begin
                    finish_d = 1'b1;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                count_d  = '0;
                rd_ptr_d = '0;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            data_out_q <= '0;
            go_q       <= 1'b0;
            finish_q   <= 1'b0;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            data_out_q <= data_out_d;
            go_q       <= go_d;
            finish_q   <= finish_d;
            busy_q     <= busy_d;
            overflow_q <= overflow_d;
        end
    end

    // NOTE: the sample store is not reset; count gates every read, so stale contents are never replayed.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_q[wr_addr] <= in_data;
        end
    end

    assign data_out = data_out_q;
    assign go       = go_q;
    assign finish   = finish_q;
    assign busy     = busy_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_range_sample_loader.sv
// Scoreboard bench for range_sample_loader: a sequence-level model queues expected
// replay beats; a negedge monitor pops and compares them whenever busy is high.
module tb_range_sample_loader;

    localparam int WIDTH = 10;
    localparam int DEPTH = 16;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_valid = 1'b0;
    logic             in_last = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] data_out;
    logic             go, finish, busy, overflow;

    range_sample_loader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clock    (clock),
        .reset    (reset),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_last  (in_last),
        .in_ready (in_ready),
        .data_out (data_out),
        .go       (go),
        .finish   (finish),
        .busy     (busy),
        .overflow (overflow)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [WIDTH-1:0] data;
        logic             go;
        logic             fin;
    } beat_t;

    beat_t            exp_q[$];
    logic [WIDTH-1:0] cur_seq[$];
    logic             exp_ovf  = 1'b0;
    logic [WIDTH-1:0] exp_hold = '0;
    int               n_tests  = 0;
    int               n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Sequence-level model: returns 1 when a complete sequence starts replay.
    function automatic bit model_accept(input logic [WIDTH-1:0] d, input logic last);
        if (cur_seq.size() == DEPTH) begin
            exp_ovf = 1'b1;
            cur_seq.delete();
            return 1'b0;
        end
        cur_seq.push_back(d);
        if (!last) return 1'b0;
        exp_ovf = 1'b0;
        foreach (cur_seq[i]) exp_q.push_back('{data: cur_seq[i], go: (i == 0), fin: 1'b0});
        exp_q.push_back('{data: cur_seq[cur_seq.size()-1], go: 1'b0, fin: 1'b1});
        cur_seq.delete();
        return 1'b1;
    endfunction

    initial begin : monitor
        beat_t b;
        forever begin
            @(negedge clock);
            if (reset) begin
                if (busy) begin
                    check("ready_in_play", in_ready, 0);
                    if (exp_q.size() == 0) begin
                        check("busy_without_expected_beat", busy, 0);
                    end else begin
                        b = exp_q.pop_front();
                        check("beat_data", data_out, b.data);
                        check("beat_go", go, b.go);
                        check("beat_finish", finish, b.fin);
                        check("beat_overflow", overflow, exp_ovf);
                        if (b.fin) exp_hold = b.data;
                    end
                end else begin
                    check("go_when_idle", go, 0);
                    check("finish_when_idle", finish, 0);
                    check("data_out_hold", data_out, exp_hold);
                end
            end
        end
    end

    task automatic wait_finish(input bit hold);
        bit seen = 1'b0;
        if (hold) begin
            in_valid = 1'b1;
            in_data  = 10'h155;
        end
        for (int c = 0; c < 3 * DEPTH; c++) begin
            @(negedge clock);
            if (hold) in_last = 1'($urandom_range(0, 1));
            if (finish) begin
                seen = 1'b1;
                break;
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (!seen) check("finish_timeout", finish, 1);
        @(posedge clock);
        #1;
        check("ready_after_finish", in_ready, 1);
    endtask

    task automatic send(input logic [WIDTH-1:0] d, input bit last, input int gap,
                        input bit hold, input bit no_wait);
        bit started;
        in_valid = 1'b0;
        repeat (gap) begin
            @(posedge clock);
            #1;
        end
        check("ready_before_send", in_ready, 1);
        in_data  = d;
        in_valid = 1'b1;
        in_last  = last;
        @(posedge clock);
        started = model_accept(d, last);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = WIDTH'($urandom);
        if (started) begin
            check("ready_after_last", in_ready, 0);
            if (!no_wait) wait_finish(hold);
        end
    endtask

    task automatic send_seq(input logic [WIDTH-1:0] s[$], input bit end_last, input bit hold);
        foreach (s[i]) begin
            send(s[i], end_last && (i == s.size() - 1), $urandom_range(0, 2), hold, 1'b0);
        end
    endtask

    initial begin : stimulus
        logic [WIDTH-1:0] s[$];
        bit seen_go;

        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_data_out", data_out, 0);
        check("rst_go", go, 0);
        check("rst_finish", finish, 0);
        check("rst_busy", busy, 0);
        check("rst_overflow", overflow, 0);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;

        s = '{10'd5, 10'd9, 10'd2, 10'd7};
        foreach (s[i]) send(s[i], i == 3, 2, 1'b0, 1'b0);

        send(10'h3FF, 1'b1, 0, 1'b0, 1'b0);

        s.delete();
        for (int i = 1; i <= DEPTH; i++) s.push_back(WIDTH'(i));
        send_seq(s, 1'b1, 1'b0);

        s.delete();
        for (int i = 1; i <= DEPTH + 1; i++) s.push_back(WIDTH'(i + 100));
        send_seq(s, 1'b0, 1'b0);
        check("overflow_set", overflow, exp_ovf);
        check("ready_after_overflow", in_ready, 1);
        repeat (5) @(posedge clock);
        #1;
        check("overflow_sticky", overflow, 1);

        s = '{10'h0AA, 10'h011};
        send_seq(s, 1'b1, 1'b0);
        check("overflow_cleared", overflow, 0);

        s = '{10'h001, 10'h002, 10'h003};
        send_seq(s, 1'b1, 1'b1);
        s = '{10'h2C4, 10'h013};
        send_seq(s, 1'b1, 1'b0);

        for (int n = 0; n < 10; n++) begin
            int len = $urandom_range(1, DEPTH);
            s.delete();
            for (int i = 0; i < len; i++) s.push_back(WIDTH'($urandom));
            send_seq(s, 1'b1, 1'($urandom_range(0, 1)));
        end

        s = '{10'h021, 10'h042, 10'h063, 10'h084};
        for (int i = 0; i < 3; i++) send(s[i], 1'b0, 1, 1'b0, 1'b0);
        send(s[3], 1'b1, 1, 1'b0, 1'b1);
        seen_go = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            if (go) begin
                seen_go = 1'b1;
                break;
            end
        end
        if (!seen_go) check("go_timeout", go, 1);
        @(posedge clock);
        #2;
        reset    = 1'b0;
        exp_q.delete();
        cur_seq.delete();
        exp_hold = '0;
        exp_ovf  = 1'b0;
        #1;
        check("midplay_rst_go", go, 0);
        check("midplay_rst_finish", finish, 0);
        check("midplay_rst_busy", busy, 0);
        check("midplay_rst_ready", in_ready, 1);
        check("midplay_rst_data", data_out, 0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        repeat (10) @(posedge clock);
        #1;

        s = '{10'h3C3, 10'h0F0, 10'h1E1};
        send_seq(s, 1'b1, 1'b0);

        repeat (3) @(posedge clock);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
